// File: rtl/mem_copy_engine_pkg.sv
// Shared constants for the memory copy/fill engine and the 32x8 data memory it drives.
package mem_copy_engine_pkg;

  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy / block fill sequencer driving the single-cycle data memory port.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_q,   state_nxt;
  logic                mode_q,    mode_nxt;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_nxt;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_nxt;
  logic [ADDR_W-1:0]   len_q,     len_nxt;
  logic [ADDR_W-1:0]   count_q,   count_nxt;
  logic [DATA_W-1:0]   fill_q,    fill_nxt;
  logic [DATA_W-1:0]   buf_q,     buf_nxt;

  // State and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      len_q     <= '0;
      count_q   <= '0;
      fill_q    <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_nxt;
      mode_q    <= mode_nxt;
      src_ptr_q <= src_ptr_nxt;
      dst_ptr_q <= dst_ptr_nxt;
      len_q     <= len_nxt;
      count_q   <= count_nxt;
      fill_q    <= fill_nxt;
      buf_q     <= buf_nxt;
    end
  end

  // Next-state and operand update
  always_comb begin
    state_nxt   = state_q;
    mode_nxt    = mode_q;
    src_ptr_nxt = src_ptr_q;
    dst_ptr_nxt = dst_ptr_q;
    len_nxt     = len_q;
    count_nxt   = count_q;
    fill_nxt    = fill_q;
    buf_nxt     = buf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_nxt    = mode;
          src_ptr_nxt = src;
          dst_ptr_nxt = dst;
          len_nxt     = len;
          fill_nxt    = fill_val;
          count_nxt   = '0;
          if (len == '0)            state_nxt = ST_DONE;
          else if (mode == MODE_COPY) state_nxt = ST_READ;
          else                        state_nxt = ST_WRITE;
        end
      end
      ST_READ: begin
        buf_nxt   = mem_rdata;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        count_nxt   = count_q + ADDR_W'(1);
        dst_ptr_nxt = dst_ptr_q + ADDR_W'(1);
        if (mode_q == MODE_COPY) src_ptr_nxt = src_ptr_q + ADDR_W'(1);
        // Pointers wrap modulo the address space by plain truncation
        if (count_nxt == len_q)       state_nxt = ST_DONE;
        else if (mode_q == MODE_COPY) state_nxt = ST_READ;
        else                          state_nxt = ST_WRITE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory port decode; held quiet during reset so no write escapes
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        ST_READ: begin
          mem_rd   = 1'b1;
          mem_addr = src_ptr_q;
        end
        ST_WRITE: begin
          mem_wr    = 1'b1;
          mem_addr  = dst_ptr_q;
          mem_wdata = (mode_q == MODE_FILL) ? fill_q : buf_q;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign done  = (state_q == ST_DONE);
  assign count = count_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized self-checking bench for mem_copy_engine against a behavioural 32x8 memory.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  localparam int unsigned AW = MEM_ADDR_W;
  localparam int unsigned DW = MEM_DATA_W;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] count;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW-1:0] len = '0;
  logic [DW-1:0] fill_val = '0;
  logic          busy, done, mem_rd, mem_wr;
  logic [AW-1:0] count, mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] mref [DEPTH];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  exp_t q[$];
  exp_t cur, act;
  logic [AW-1:0] exp_count = '0;

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .count(count),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, write on the edge
  always @(posedge clk) begin
    if (pl_we)       mem[pl_addr]  <= pl_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  // Per-cycle compare against the expected-cycle queue
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
        errors++;
        $display("FAIL rst_gate cyc=%0d: rd=%0b wr=%0b addr=%0d wdata=%0h required all zero",
                 cyc, mem_rd, mem_wr, mem_addr, mem_wdata);
      end
      q.delete();
      exp_count = '0;
    end else begin
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur = '0;
        cur.count = exp_count;
      end
      exp_count = cur.count;
      act = {busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, count};
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL cycle cyc=%0d: got busy=%0b done=%0b rd=%0b wr=%0b addr=%0d wdata=%0h count=%0d required busy=%0b done=%0b rd=%0b wr=%0b addr=%0d wdata=%0h count=%0d",
                 cyc, act.busy, act.done, act.rd, act.wr, act.addr, act.wdata, act.count,
                 cur.busy, cur.done, cur.rd, cur.wr, cur.addr, cur.wdata, cur.count);
      end
      if (cur.wr) mref[cur.addr] = cur.wdata;
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if (busy)   busy_cnt++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc + 1;
      end
    end
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, actual, required);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    mref[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issue a start and queue the cycle-by-cycle outcome from a byte-level model
  task automatic launch(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW-1:0] l, input logic [DW-1:0] f, output int k);
    logic [DW-1:0] tmp [DEPTH];
    logic [DW-1:0] b;
    exp_t e;
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = cyc;
    tmp = mref;
    for (int j = 0; j < int'(l); j++) begin
      if (m == MODE_COPY) begin
        e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = s + AW'(j); e.count = AW'(j);
        q.push_back(e);
        b = tmp[s + AW'(j)];
      end else b = f;
      e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = d + AW'(j); e.wdata = b; e.count = AW'(j);
      q.push_back(e);
      tmp[d + AW'(j)] = b;
    end
    e = '0; e.done = 1'b1; e.count = l;
    q.push_back(e);
  endtask

  // Optionally poke start mid-operation, then wait for the engine to settle
  task automatic finish_op(input int intrude_at);
    if (intrude_at >= 0) begin
      repeat (intrude_at) begin @(posedge clk); #1; end
      mode = 1'($urandom); src = AW'($urandom); dst = AW'($urandom);
      len = AW'($urandom); fill_val = DW'($urandom); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("op_completes", q.size(), 0);
    q.delete();
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== mref[i]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int k, r0, w0, b0, d0, lat;
    logic m;
    logic [AW-1:0] s, d, l;
    logic [DW-1:0] f, ref3, ref21, ref22;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    for (int i = 0; i < int'(DEPTH); i++) preload(AW'(i), DW'($urandom));
    preload(5'd0, 8'd14); preload(5'd1, 8'd15); preload(5'd2, 8'd12);

    // Copy 0->8 len 3, with an ignored start while busy
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    launch(MODE_COPY, 5'd0, 5'd8, 5'd3, 8'h00, k);
    finish_op(2);
    check("copy_latency", last_done_cyc - k, 7);
    check("copy_mem8", int'(mem[8]), 14);
    check("copy_mem9", int'(mem[9]), 15);
    check("copy_mem10", int'(mem[10]), 12);
    check("copy_count", int'(count), 3);
    check("copy_rd_cycles", rd_cnt - r0, 3);
    check("copy_wr_cycles", wr_cnt - w0, 3);
    check("copy_single_done", done_cnt - d0, 1);
    check_mem("copy_mem_image");

    // Fill 4..8 with 0xA5
    ref3 = mref[3]; b0 = busy_cnt;
    launch(MODE_FILL, 5'd4, 5'd4, 5'd5, 8'hA5, k);
    finish_op(-1);
    for (int i = 4; i <= 8; i++) check("fill_byte", int'(mem[i]), 8'hA5);
    check("fill_mem3", int'(mem[3]), int'(ref3));
    check("fill_mem9", int'(mem[9]), 15);
    check("fill_busy_cycles", busy_cnt - b0, 5);
    check("fill_latency", last_done_cyc - k, 6);
    check_mem("fill_mem_image");

    // Fill wrapping past the top of memory
    launch(MODE_FILL, 5'd0, 5'd30, 5'd4, 8'h3C, k);
    finish_op(-1);
    check("wrap_mem30", int'(mem[30]), 8'h3C);
    check("wrap_mem31", int'(mem[31]), 8'h3C);
    check("wrap_mem0", int'(mem[0]), 8'h3C);
    check("wrap_mem1", int'(mem[1]), 8'h3C);
    check("wrap_mem2", int'(mem[2]), 12);

    // Zero length
    r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
    launch(MODE_COPY, 5'd5, 5'd6, 5'd0, 8'h00, k);
    finish_op(-1);
    check("len0_latency", last_done_cyc - k, 1);
    check("len0_busy", busy_cnt - b0, 0);
    check("len0_rd", rd_cnt - r0, 0);
    check("len0_wr", wr_cnt - w0, 0);
    check("len0_done", done_cnt - d0, 1);
    check("len0_count", int'(count), 0);

    // Overlapping ascending copy smears the first byte
    preload(5'd0, 8'd14); preload(5'd1, 8'd15); preload(5'd2, 8'd12);
    launch(MODE_COPY, 5'd0, 5'd1, 5'd3, 8'h00, k);
    finish_op(-1);
    for (int i = 0; i <= 3; i++) check("overlap_byte", int'(mem[i]), 14);
    check_mem("overlap_mem_image");

    // Reset during the second write of a 3-byte copy
    ref21 = mref[21]; ref22 = mref[22]; d0 = done_cnt; w0 = wr_cnt;
    launch(MODE_COPY, 5'd0, 5'd20, 5'd3, 8'h00, k);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(count), 0);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_mem20", int'(mem[20]), 14);
    check("abort_mem21", int'(mem[21]), int'(ref21));
    check("abort_mem22", int'(mem[22]), int'(ref22));
    check("abort_wr_cycles", wr_cnt - w0, 1);
    check("abort_no_done", done_cnt - d0, 0);
    check_mem("abort_mem_image");

    // Random operations
    for (int n = 0; n < 20; n++) begin
      int bl;
      m = 1'($urandom); s = AW'($urandom); d = AW'($urandom);
      l = AW'($urandom_range(0, 12)); f = DW'($urandom);
      if (n == 0) l = 5'd31;
      bl = (l == 0) ? 0 : ((m == MODE_COPY) ? 2 * int'(l) : int'(l));
      d0 = done_cnt;
      launch(m, s, d, l, f, k);
      finish_op(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, bl)) : -1);
      lat = (l == 0) ? 1 : ((m == MODE_COPY) ? 2 * int'(l) + 1 : int'(l) + 1);
      check("rand_latency", last_done_cyc - k, lat);
      check("rand_done", done_cnt - d0, 1);
      check("rand_count", int'(count), int'(l));
      check_mem("rand_mem_image");
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side sequencer for the 32x8 single-cycle data memory.
- Performs block copy (read source, write destination) or block fill (write constant) over the memory's wr/rd/address/data port.
- Started by a control pulse from the processor/testbench; reports busy, progress count and a one-cycle done pulse.
- Sits between the control path and the data memory port, muxed with the datapath's load/store signals.

Parameters:
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, memory data width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill; latched on accepted start
- src  input  ADDR_W  copy source base address; latched on start
- dst  input  ADDR_W  destination base address; latched on start
- len  input  ADDR_W  byte count 0..31; latched on start
- fill_val  input  DATA_W  fill constant; latched on start
- busy  output  1  high in READ/WRITE states
- done  output  1  one-cycle pulse in DONE state
- count  output  ADDR_W  bytes written so far
- mem_rd  output  1  to memory rd
- mem_wr  output  1  to memory wr
- mem_addr  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory data_write
- mem_rdata  input  DATA_W  from memory data_read (combinational, valid same cycle as mem_rd)

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, count=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, internal pointers/buffer=0.
- mem_* outputs are combinational decodes of the state registers, gated low while rst=1. No write escapes during a reset cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 latches mode/src/dst/len/fill_val and clears count.
  - If len=0, next state is DONE.
  - Else if mode=0, next state is READ; else next state is WRITE.
  - start in any other state is ignored; no queuing.
- READ (copy only): mem_rd=1, mem_addr=src_ptr. mem_rdata is captured into the byte buffer at the edge. Next state is WRITE.
- WRITE:
  - mem_wr=1, mem_addr=dst_ptr.
  - mem_wdata = buffer (copy) or fill_val (fill).
  - At the edge: count+1, dst_ptr+1, and src_ptr+1 (copy).
  - If count+1==len, go to DONE; else go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 for exactly one cycle, busy=0. count holds len. Next state is IDLE.
- Latency: start accepted at edge k.
  - Copy of N bytes: busy is high for cycles k+1..k+2N; done is high in cycle k+2N+1.
  - Fill: busy for k+1..k+N; done in cycle k+N+1.
  - len=0: done in cycle k+1, no memory access.
- Address arithmetic is modulo 2^ADDR_W; pointers wrap 31 to 0 silently.
- Overlapping copy is strictly ascending, byte by byte.
  - With dst in (src, src+len), already-written bytes are re-read. This smearing is defined behaviour, not an error.
  - src==dst rewrites identical data.
- count resets to 0 only on rst or an accepted start; it holds its final value in IDLE.
- Reset asserted mid-operation aborts immediately. The next cycle is IDLE with all outputs at reset values; memory keeps the bytes already written.
- mem_rd and mem_wr are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3
  - MODE_COPY=1'b0, MODE_FILL=1'b1
  - ADDR_W/DATA_W defaults, shared with the data memory
- No sub-module; a single always block for state/counters plus one combinational output decode.
- The bench instantiates this engine against the existing data memory.

Test Plan:
- Reset, then memory preloaded [0]=14,[1]=15,[2]=12; copy src=0,dst=8,len=3 -> done in cycle k+7; mem[8..10]=14,15,12; count=3; exactly 3 rd and 3 wr cycles.
- Fill mode=1,dst=4,len=5,fill_val=0xA5 -> mem[4..8]=0xA5, mem[3] and mem[9] unchanged; busy exactly 5 cycles; done in cycle k+6.
- Wrap-around: fill dst=30,len=4,fill_val=0x3C -> mem[30],mem[31],mem[0],mem[1]=0x3C; mem[2] stays 12.
- len=0 start -> done pulse in cycle k+1, busy never high, no mem_rd/mem_wr; start pulsed while busy during a len=3 copy -> ignored, single done.
- Overlap: copy src=0,dst=1,len=3 with preload 14,15,12 -> mem[0..3]=14,14,14,14.
- Reset mid-copy (rst high in second WRITE of a len=3 copy) -> mem_wr=0 during the rst cycle; only the first destination byte written; state IDLE, count=0, done never pulses.
